decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV64I decode stage; receiving end of the fetch->decode latch (DE_NPC/DE_PC/DE_IR/DE_V).
//  Decodes the instruction, generates the sign-extended immediate and reads rs1/rs2 from the register file.
//  Tracks in-flight destinations with a scoreboard and drives V_DEP_STALL and V_DE_FE_BR_STALL back to fetch.
//  Registers results into the decode->execute latch (EXE_*).
// PARAMETERS
//  XLEN      64  datapath width
//  NREGS     32  architectural registers; x0 hardwired to 0
// PORTS
//  CLK               in   1     clock
//  RESET             in   1     synchronous, active-high reset
//  DE_NPC            in   64    PC+4 from fetch
//  DE_PC             in   64    instruction PC from fetch
//  DE_IR             in   32    instruction word
//  DE_V              in   1     DE latch valid
//  WB_V              in   1     writeback valid
//  WB_RD             in   5     writeback destination
//  WB_DATA           in   64    writeback data
//  V_DEP_STALL       out  1     comb; hold fetch PC and DE latch
//  V_DE_FE_BR_STALL  out  1     comb; control-flow op in decode; fetch freezes PC and sends bubbles
//  EXE_V             out  1     EXE latch valid
//  EXE_PC/EXE_NPC    out  64    forwarded PC / NPC
//  EXE_IR            out  32    forwarded instruction
//  EXE_RS1_VAL       out  64    rs1 operand
//  EXE_RS2_VAL       out  64    rs2 operand
//  EXE_IMM           out  64    sign-extended immediate
//  EXE_RD            out  5     destination register, 0 when no write
//  EXE_ILLEGAL       out  1     opcode not in the RV64I set
// BEHAVIOUR
//  - Reset: all EXE_* = 0; scoreboard busy[] = 0; regfile x0..x31 = 0.
//  - Opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32.
//  - Immediates: I/S/B/U/J formats, all sign-extended from the top instruction bit to 64b.
//  - rs1 used by all classes except LUI, AUIPC, JAL; rs2 used by BRANCH, STORE, OP, OP-32.
//  - rd written by all classes except BRANCH and STORE; rd=x0 counts as no write (EXE_RD=0).
//  - hazard(r) = busy[r] && !(WB_V && WB_RD==r); x0 never busy.
//  - V_DEP_STALL = DE_V && (used rs1 hazard || used rs2 hazard || written rd hazard, i.e. WAW).
//  - V_DE_FE_BR_STALL = DE_V && opcode in {BRANCH, JAL, JALR}; asserts in the same cycle, independent of V_DEP_STALL.
//  - Latency: 1 cycle DE->EXE. EXE_V <= DE_V && !V_DEP_STALL; on stall a bubble is issued and the other EXE_* values are don't-care.
//  - Issue: when EXE_V is loaded with 1 and rd!=0, set busy[rd].
//  - Writeback: when WB_V is set and WB_RD!=0, write the regfile and clear busy[WB_RD].
//  - Simultaneous set and clear of the same register: set wins, because the new producer is younger.
//  - Regfile is write-first: a read of WB_RD in the WB cycle returns WB_DATA, so the stall drops in that cycle.
//  - Writes to x0 are ignored; x0 always reads 0.
//  - Illegal opcode: EXE_ILLEGAL=1, rd treated as 0, no stall, no scoreboard update.
//  - RESET mid-stall: busy[] cleared, stalls deassert the next cycle (they are comb from a cleared scoreboard and DE_V).
//  - No downstream backpressure: execute accepts every cycle.
// STRUCTURE
//  - Shared package rv64_pkg: opcode localparams, imm-type enum {I,S,B,U,J,NONE}, XLEN.
//  - Sub-module register_file: NREGS x XLEN, 2 async reads, 1 sync write, write-first bypass, x0 = 0.
//  - Top level holds the decoder, immediate generator, scoreboard and EXE latch.
// TESTING
//  1. RESET for 2 cycles -> EXE_V=0, both stalls 0; register reads of x1..x31 return 0.
//  2. ADDI x3,x0,-1 (0xFFF00193), DE_V=1 -> next cycle EXE_V=1, EXE_RD=3, EXE_IMM=0xFFFFFFFFFFFFFFFF.
//     LUI x4,0x80000 (0x80000237) -> EXE_IMM=0xFFFFFFFF80000000.
//  3. Dependency: ADDI x1,x0,5 (0x00500093), then ADD x2,x1,x1 (0x00108133) -> V_DEP_STALL=1 and EXE_V=0
//     until WB_V=1 with WB_RD=1, WB_DATA=5; in that cycle the stall drops; next cycle EXE_RS1_VAL=EXE_RS2_VAL=5.
//  4. BEQ x0,x0,0 (0x00000063), DE_V=1 -> V_DE_FE_BR_STALL=1 in the same cycle; next cycle EXE_V=1, EXE_RD=0, no busy set.
//  5. WB_V=1, WB_RD=0, WB_DATA=0xDEAD -> x0 still reads 0 and nothing stalls. Same-cycle issue of rd=7 and WB of x7 -> busy[7] stays 1.
//  6. Assert RESET while V_DEP_STALL=1 -> busy[] cleared; the previously stalled instruction issues with EXE_V=1 after reset.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared RV64I definitions: opcodes, immediate formats and the decode->execute latch layout.
package rv64_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    typedef struct packed {
        logic            v;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [31:0]     ir;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            illegal;
    } exe_t;

    // The opcode field is not needed here, so only ir[31:7] is passed in.
    function automatic logic [XLEN-1:0] gen_imm(imm_type_e t, logic [31:7] ir);
        logic [XLEN-1:0] imm;
        case (t)
            IMM_I:   imm = {{52{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm = {{32{ir[31]}}, ir[31:12], 12'b0};
            IMM_J:   imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback/execute signals around the decode stage; decode is the slave side.
interface decode_stage_if;
    import rv64_pkg::*;

    logic [XLEN-1:0] DE_NPC;
    logic [XLEN-1:0] DE_PC;
    logic [31:0]     DE_IR;
    logic            DE_V;
    logic            WB_V;
    logic [4:0]      WB_RD;
    logic [XLEN-1:0] WB_DATA;
    logic            V_DEP_STALL;
    logic            V_DE_FE_BR_STALL;
    logic            EXE_V;
    logic [XLEN-1:0] EXE_PC;
    logic [XLEN-1:0] EXE_NPC;
    logic [31:0]     EXE_IR;
    logic [XLEN-1:0] EXE_RS1_VAL;
    logic [XLEN-1:0] EXE_RS2_VAL;
    logic [XLEN-1:0] EXE_IMM;
    logic [4:0]      EXE_RD;
    logic            EXE_ILLEGAL;

    modport master (
        output DE_NPC, DE_PC, DE_IR, DE_V, WB_V, WB_RD, WB_DATA,
        input  V_DEP_STALL, V_DE_FE_BR_STALL, EXE_V, EXE_PC, EXE_NPC, EXE_IR,
               EXE_RS1_VAL, EXE_RS2_VAL, EXE_IMM, EXE_RD, EXE_ILLEGAL
    );

    modport slave (
        input  DE_NPC, DE_PC, DE_IR, DE_V, WB_V, WB_RD, WB_DATA,
        output V_DEP_STALL, V_DE_FE_BR_STALL, EXE_V, EXE_PC, EXE_NPC, EXE_IR,
               EXE_RS1_VAL, EXE_RS2_VAL, EXE_IMM, EXE_RD, EXE_ILLEGAL
    );
endinterface

// File: rtl/register_file.sv
// Integer register file: two async read ports, one sync write port with write-first bypass, x0 = 0.
module register_file
    import rv64_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [NREGS-1:0][XLEN-1:0] mem_q;
    logic [NREGS-1:0][XLEN-1:0] mem_d;
    logic                       wr_en;

    assign wr_en = we && (wa != 5'd0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wa] = wd;
    end

    always_ff @(posedge CLK) begin
        if (RESET) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    // Bypass lets a consumer waiting on WB_RD issue in the writeback cycle.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) rd1 = (wr_en && wa == ra1) ? wd : mem_q[ra1];
        if (ra2 != 5'd0) rd2 = (wr_en && wa == ra2) ? wd : mem_q[ra2];
    end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode: instruction decode, immediate generation, operand read, scoreboard hazards
// and the decode->execute latch.
module decode_stage
    import rv64_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    decode_stage_if.slave io
);

    logic [6:0]      opcode;
    logic [4:0]      rd_f, rs1_f, rs2_f, rd_eff;
    logic            use_rs1, use_rs2, writes_rd, is_cf, illegal;
    imm_type_e       imm_t;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            hz_rs1, hz_rs2, hz_rd, dep_stall, exe_v_d;
    logic [NREGS-1:0] busy_q, busy_d;
    exe_t            exe_q, exe_d;

    assign opcode = io.DE_IR[6:0];
    assign rd_f   = io.DE_IR[11:7];
    assign rs1_f  = io.DE_IR[19:15];
    assign rs2_f  = io.DE_IR[24:20];

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        is_cf     = 1'b0;
        illegal   = 1'b0;
        imm_t     = IMM_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin writes_rd = 1'b1; imm_t = IMM_U; end
            OPC_JAL:            begin writes_rd = 1'b1; imm_t = IMM_J; is_cf = 1'b1; end
            OPC_JALR:           begin writes_rd = 1'b1; use_rs1 = 1'b1; imm_t = IMM_I; is_cf = 1'b1; end
            OPC_BRANCH:         begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_t = IMM_B; is_cf = 1'b1; end
            OPC_STORE:          begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_t = IMM_S; end
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32:
                                begin writes_rd = 1'b1; use_rs1 = 1'b1; imm_t = IMM_I; end
            OPC_OP, OPC_OP_32:  begin writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default:            illegal = 1'b1;
        endcase
    end

    assign rd_eff = writes_rd ? rd_f : 5'd0;

    // A register whose producer is writing back this cycle is readable through the bypass.
    assign hz_rs1 = (rs1_f != 5'd0) && busy_q[rs1_f] && !(io.WB_V && io.WB_RD == rs1_f);
    assign hz_rs2 = (rs2_f != 5'd0) && busy_q[rs2_f] && !(io.WB_V && io.WB_RD == rs2_f);
    assign hz_rd  = (rd_eff != 5'd0) && busy_q[rd_eff] && !(io.WB_V && io.WB_RD == rd_eff);

    assign dep_stall = io.DE_V && ((use_rs1 && hz_rs1) || (use_rs2 && hz_rs2) || hz_rd);
    assign exe_v_d   = io.DE_V && !dep_stall;

    assign io.V_DEP_STALL      = dep_stall;
    assign io.V_DE_FE_BR_STALL = io.DE_V && is_cf;

    register_file u_rf (
        .CLK   (CLK),
        .RESET (RESET),
        .ra1   (rs1_f),
        .ra2   (rs2_f),
        .rd1   (rs1_val),
        .rd2   (rs2_val),
        .we    (io.WB_V),
        .wa    (io.WB_RD),
        .wd    (io.WB_DATA)
    );

    // Set is applied after clear so a newly issued producer wins over an older writeback.
    always_comb begin
        busy_d = busy_q;
        if (io.WB_V && io.WB_RD != 5'd0) busy_d[io.WB_RD] = 1'b0;
        if (exe_v_d && rd_eff != 5'd0)   busy_d[rd_eff]   = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        exe_d.v       = exe_v_d;
        exe_d.pc      = io.DE_PC;
        exe_d.npc     = io.DE_NPC;
        exe_d.ir      = io.DE_IR;
        exe_d.rs1_val = rs1_val;
        exe_d.rs2_val = rs2_val;
        exe_d.imm     = gen_imm(imm_t, io.DE_IR[31:7]);
        exe_d.rd      = rd_eff;
        exe_d.illegal = illegal;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_q <= '0;
            exe_q  <= '0;
        end else begin
            busy_q <= busy_d;
            exe_q  <= exe_d;
        end
    end

    assign io.EXE_V       = exe_q.v;
    assign io.EXE_PC      = exe_q.pc;
    assign io.EXE_NPC     = exe_q.npc;
    assign io.EXE_IR      = exe_q.ir;
    assign io.EXE_RS1_VAL = exe_q.rs1_val;
    assign io.EXE_RS2_VAL = exe_q.rs2_val;
    assign io.EXE_IMM     = exe_q.imm;
    assign io.EXE_RD      = exe_q.rd;
    assign io.EXE_ILLEGAL = exe_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, immediates, scoreboard stalls, bypass and reset.
module tb_decode_stage;
    import rv64_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    decode_stage_if io();

    decode_stage dut (
        .CLK   (CLK),
        .RESET (RESET),
        .io    (io)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir);
        io.DE_V   = v;
        io.DE_IR  = ir;
        io.DE_PC  = 64'h1000;
        io.DE_NPC = 64'h1004;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [63:0] data);
        io.WB_V    = v;
        io.WB_RD   = rd;
        io.WB_DATA = data;
    endtask

    initial begin
        RESET = 1'b1;
        wb(1'b0, 5'd0, 64'd0);
        drive(1'b0, 32'h0);

        // 1. reset
        step();
        step();
        RESET = 1'b0;
        check("rst_exe_v", io.EXE_V, 0);
        check("rst_exe_rd", io.EXE_RD, 0);
        check("rst_exe_imm", io.EXE_IMM, 0);
        check("rst_dep_stall", io.V_DEP_STALL, 0);
        check("rst_br_stall", io.V_DE_FE_BR_STALL, 0);
        for (int i = 1; i < 32; i++) begin
            // ADD x0, xi, xi: reads both ports, writes nothing
            drive(1'b1, (32'(i) << 20) | (32'(i) << 15) | 32'h33);
            step();
            check("rst_rf_rs1", io.EXE_RS1_VAL, 0);
            check("rst_rf_rs2", io.EXE_RS2_VAL, 0);
        end

        // 2. immediates
        drive(1'b1, 32'hFFF00193);
        step();
        check("addi_v", io.EXE_V, 1);
        check("addi_rd", io.EXE_RD, 3);
        check("addi_imm", io.EXE_IMM, 64'hFFFFFFFFFFFFFFFF);
        check("addi_pc", io.EXE_PC, 64'h1000);
        check("addi_npc", io.EXE_NPC, 64'h1004);
        drive(1'b1, 32'h80000237);
        step();
        check("lui_imm", io.EXE_IMM, 64'hFFFFFFFF80000000);
        check("lui_rd", io.EXE_RD, 4);
        drive(1'b0, 32'h0);
        wb(1'b1, 5'd3, 64'h33);
        step();
        wb(1'b1, 5'd4, 64'h44);
        step();
        wb(1'b0, 5'd0, 64'd0);

        // 3. RAW dependency resolved by writeback bypass
        drive(1'b1, 32'h00500093);
        step();
        check("dep_addi_v", io.EXE_V, 1);
        drive(1'b1, 32'h00108133);
        check("dep_stall_on", io.V_DEP_STALL, 1);
        step();
        check("dep_bubble1", io.EXE_V, 0);
        check("dep_stall_hold", io.V_DEP_STALL, 1);
        step();
        check("dep_bubble2", io.EXE_V, 0);
        wb(1'b1, 5'd1, 64'd5);
        #1;
        check("dep_stall_drop", io.V_DEP_STALL, 0);
        step();
        wb(1'b0, 5'd0, 64'd0);
        drive(1'b0, 32'h0);
        check("dep_add_v", io.EXE_V, 1);
        check("dep_add_rd", io.EXE_RD, 2);
        check("dep_rs1", io.EXE_RS1_VAL, 5);
        check("dep_rs2", io.EXE_RS2_VAL, 5);

        // WAW on x2 (still busy from the ADD)
        drive(1'b1, 32'h00000113);
        check("waw_stall", io.V_DEP_STALL, 1);
        wb(1'b1, 5'd2, 64'd10);
        #1;
        check("waw_drop", io.V_DEP_STALL, 0);
        step();
        wb(1'b0, 5'd0, 64'd0);
        drive(1'b0, 32'h0);
        wb(1'b1, 5'd2, 64'd0);
        step();
        wb(1'b0, 5'd0, 64'd0);

        // 4. branch
        drive(1'b1, 32'h00000063);
        check("beq_br_stall", io.V_DE_FE_BR_STALL, 1);
        check("beq_dep_stall", io.V_DEP_STALL, 0);
        step();
        check("beq_v", io.EXE_V, 1);
        check("beq_rd", io.EXE_RD, 0);
        check("beq_imm", io.EXE_IMM, 0);
        // illegal opcode 0x7F
        drive(1'b1, 32'h00000FFF);
        check("ill_br_stall", io.V_DE_FE_BR_STALL, 0);
        check("ill_dep_stall", io.V_DEP_STALL, 0);
        step();
        check("ill_flag", io.EXE_ILLEGAL, 1);
        check("ill_rd", io.EXE_RD, 0);

        // 5. writes to x0 ignored; same-cycle issue and writeback of x7
        wb(1'b1, 5'd0, 64'hDEAD);
        drive(1'b1, 32'h00000033);
        check("x0wb_stall", io.V_DEP_STALL, 0);
        step();
        check("x0wb_rs1", io.EXE_RS1_VAL, 0);
        check("x0wb_ill", io.EXE_ILLEGAL, 0);
        wb(1'b1, 5'd7, 64'h77);
        drive(1'b1, 32'h00100393);
        step();
        wb(1'b0, 5'd0, 64'd0);
        check("x7_issue_rd", io.EXE_RD, 7);
        drive(1'b1, 32'h00038433);
        check("x7_busy_kept", io.V_DEP_STALL, 1);

        // 6. reset during a stall
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rst_mid_exe_v", io.EXE_V, 0);
        check("rst_mid_stall", io.V_DEP_STALL, 0);
        step();
        check("post_rst_v", io.EXE_V, 1);
        check("post_rst_rd", io.EXE_RD, 8);
        check("post_rst_rs1", io.EXE_RS1_VAL, 0);
        drive(1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
